// File: rtl/hs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hs_rr_arbiter
//
// Round-robin arbiter that merges INPUTS handshaked requesters onto a single
// handshaked sink. A requester that wins with a non-last beat keeps the grant
// until its last beat has been transferred, so frames are never interleaved.
// The output stage is a registered skid-less pipeline register that sustains
// one beat per cycle while the sink is ready.
//
// Parameters
//   DATA_WIDTH : payload width per input
//   INPUTS     : number of requesters (2..16)
//   IDX_WIDTH  : width of source index fields, $clog2(INPUTS)
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   dataIn_data  in   INPUTS*DATA_WIDTH, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dataIn_last  in   INPUTS, end-of-frame flag per input
//   dataIn_vld   in   INPUTS, valid per input
//   dataIn_rd    out  INPUTS, ready per input (one-hot or zero, combinational)
//   dataOut_data out  DATA_WIDTH, registered payload
//   dataOut_last out  registered end-of-frame flag
//   dataOut_src  out  IDX_WIDTH, index of the input that produced the beat
//   dataOut_vld  out  output valid
//   dataOut_rd   in   output ready
//   busy         out  high while a frame lock is held
// -----------------------------------------------------------------------------
module hs_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 4,
  parameter int IDX_WIDTH  = $clog2(INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*DATA_WIDTH-1:0] dataIn_data,
  input  logic [INPUTS-1:0]            dataIn_last,
  input  logic [INPUTS-1:0]            dataIn_vld,
  output logic [INPUTS-1:0]            dataIn_rd,
  output logic [DATA_WIDTH-1:0]        dataOut_data,
  output logic                         dataOut_last,
  output logic [IDX_WIDTH-1:0]         dataOut_src,
  output logic                         dataOut_vld,
  input  logic                         dataOut_rd,
  output logic                         busy
);

  // Sum width is one bit wider than an index so ptr+offset cannot overflow
  // before the modulo-INPUTS correction.
  localparam int                 SUM_WIDTH = IDX_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] INPUTS_W = SUM_WIDTH'(INPUTS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(INPUTS - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INPUTS-1:0]    ONEHOT_0 = {{(INPUTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Arbitration state
  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic [IDX_WIDTH-1:0] w_ptr_nxt;
  logic [IDX_WIDTH-1:0] r_lock_idx;
  logic [IDX_WIDTH-1:0] w_lock_nxt;

  // Output register
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [IDX_WIDTH-1:0]  r_src;
  logic                  r_vld;

  // Selection datapath
  logic [DATA_WIDTH-1:0] w_data_arr [INPUTS];
  logic [2*INPUTS-1:0]   w_rot_dbl;
  logic [INPUTS-1:0]     w_rot;
  logic [IDX_WIDTH-1:0]  w_off;
  logic [SUM_WIDTH-1:0]  w_sum;
  logic [IDX_WIDTH-1:0]  w_idle_sel;
  logic [IDX_WIDTH-1:0]  w_sel;
  logic                  w_sel_exists;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic [IDX_WIDTH-1:0]  w_ptr_inc;
  logic                  w_can_accept;
  logic                  w_xfer;

  // Unpack the flat payload bus so the winner can be picked by index.
  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_unpack
    assign w_data_arr[gi] = dataIn_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: rotate the valid vector so bit 0 corresponds to ptr,
  // find the lowest set bit, then map the offset back modulo INPUTS. The
  // explicit subtract keeps the wrap correct when INPUTS is not a power of 2.
  always_comb begin
    w_rot_dbl = {dataIn_vld, dataIn_vld} >> r_ptr;
    w_rot     = w_rot_dbl[INPUTS-1:0];
    w_off     = IDX_ZERO;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? IDX_WIDTH'(k) : w_off;
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= INPUTS_W) begin
      w_idle_sel = IDX_WIDTH'(w_sum - INPUTS_W);
    end else begin
      w_idle_sel = w_sum[IDX_WIDTH-1:0];
    end
  end

  // Choose the candidate: free round-robin in IDLE, the lock holder only in
  // LOCKED (other valid inputs are deliberately ignored until the frame ends).
  always_comb begin
    w_sel        = w_idle_sel;
    w_sel_exists = |dataIn_vld;
    case (r_state)
      ST_IDLE: begin
        w_sel        = w_idle_sel;
        w_sel_exists = |dataIn_vld;
      end
      ST_LOCKED: begin
        w_sel        = r_lock_idx;
        w_sel_exists = dataIn_vld[r_lock_idx];
      end
      default: begin
        w_sel        = w_idle_sel;
        w_sel_exists = |dataIn_vld;
      end
    endcase
  end

  // The output register can take a beat when it is empty or draining this
  // cycle; reset forces all readies low.
  assign w_can_accept = (~r_vld | dataOut_rd) & ~rst;
  assign w_xfer       = w_can_accept & w_sel_exists;
  assign dataIn_rd    = w_xfer ? (ONEHOT_0 << w_sel) : {INPUTS{1'b0}};
  assign w_sel_data   = w_data_arr[w_sel];
  assign w_sel_last   = dataIn_last[w_sel];
  assign w_ptr_inc    = (w_sel == LAST_IDX) ? IDX_ZERO : (w_sel + IDX_ONE);

  // Next-state logic: a non-last beat locks onto the winner without moving
  // ptr; a last beat releases the lock and advances ptr past the winner.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock_idx;
    if (w_xfer) begin
      if (w_sel_last) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = w_ptr_inc;
        w_lock_nxt  = r_lock_idx;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = w_sel;
      end
    end else begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_lock_nxt  = r_lock_idx;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_ZERO;
      r_lock_idx <= IDX_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_idx <= w_lock_nxt;
    end
  end

  // Output pipeline register: load on transfer, empty on drain, else hold so
  // the payload stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= {DATA_WIDTH{1'b0}};
      r_last <= 1'b0;
      r_src  <= IDX_ZERO;
      r_vld  <= 1'b0;
    end else if (w_xfer) begin
      r_data <= w_sel_data;
      r_last <= w_sel_last;
      r_src  <= w_sel;
      r_vld  <= 1'b1;
    end else if (r_vld & dataOut_rd) begin
      r_vld  <= 1'b0;
    end else begin
      r_vld  <= r_vld;
    end
  end

  assign dataOut_data = r_data;
  assign dataOut_last = r_last;
  assign dataOut_src  = r_src;
  assign dataOut_vld  = r_vld;
  assign busy         = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hs_rr_arbiter
//
// Directed bench for hs_rr_arbiter. One 4-input instance covers reset,
// fairness, frame lock, backpressure, bubbles and reset mid-frame; a 3-input
// instance covers the non-power-of-2 wrap. Inputs change 1 ns after a rising
// edge; combinational readies are sampled 1 ns later, registered outputs
// 1 ns after the edge that loads them.
// -----------------------------------------------------------------------------
module tb_hs_rr_arbiter;

  logic clk;
  logic rst;

  // 4-input instance
  logic [31:0] data4;
  logic [3:0]  last4;
  logic [3:0]  vld4;
  logic [3:0]  rd4;
  logic [7:0]  odata4;
  logic        olast4;
  logic [1:0]  osrc4;
  logic        ovld4;
  logic        ordy4;
  logic        busy4;

  // 3-input instance
  logic [23:0] data3;
  logic [2:0]  last3;
  logic [2:0]  vld3;
  logic [2:0]  rd3;
  logic [7:0]  odata3;
  logic        olast3;
  logic [1:0]  osrc3;
  logic        ovld3;
  logic        ordy3;
  logic        busy3;

  int errors;
  int checks;

  hs_rr_arbiter #(.DATA_WIDTH(8), .INPUTS(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .dataIn_data  (data4),
    .dataIn_last  (last4),
    .dataIn_vld   (vld4),
    .dataIn_rd    (rd4),
    .dataOut_data (odata4),
    .dataOut_last (olast4),
    .dataOut_src  (osrc4),
    .dataOut_vld  (ovld4),
    .dataOut_rd   (ordy4),
    .busy         (busy4)
  );

  hs_rr_arbiter #(.DATA_WIDTH(8), .INPUTS(3)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .dataIn_data  (data3),
    .dataIn_last  (last3),
    .dataIn_vld   (vld3),
    .dataIn_rd    (rd3),
    .dataOut_data (odata3),
    .dataOut_last (olast3),
    .dataOut_src  (osrc3),
    .dataOut_vld  (ovld3),
    .dataOut_rd   (ordy3),
    .busy         (busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    vld4  = 4'b0000;
    last4 = 4'b0000;
    data4 = 32'h0;
    ordy4 = 1'b1;
    vld3  = 3'b000;
    last3 = 3'b000;
    data3 = 24'h0;
    ordy3 = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    vld4  = 4'b1111;
    last4 = 4'b1111;
    data4 = 32'h30_20_10_00;
    ordy4 = 1'b1;
    vld3  = 3'b000;
    last3 = 3'b000;
    data3 = 24'h0;
    ordy3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rd4 !== 4'b0000) begin
        errors++;
        $display("FAIL reset_rd cycle %0d: got %b expected 0000", c, rd4);
      end
      tick();
    end
    checks++;
    if (ovld4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld: got %b expected 0", ovld4);
    end
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rd4 !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant_rd: got %b expected 0001", rd4);
    end
    checks++;
    if (ovld4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld_after_release: got %b expected 0", ovld4);
    end
    tick();
    checks++;
    if (ovld4 !== 1'b1 || osrc4 !== 2'd0 || odata4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_beat: got vld=%b src=%0d data=%h expected vld=1 src=0 data=00",
               ovld4, osrc4, odata4);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rd;
    logic [1:0] exp_src;
    logic [7:0] exp_data;
    do_reset();
    vld4  = 4'b1111;
    last4 = 4'b1111;
    data4 = 32'h30_20_10_00;
    ordy4 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_src  = 2'(j % 4);
      exp_rd   = 4'b0001 << exp_src;
      exp_data = 8'(8'h10 * (j % 4) + (j / 4));
      #1;
      checks++;
      if (rd4 !== exp_rd) begin
        errors++;
        $display("FAIL fair_rd beat %0d: got %b expected %b", j, rd4, exp_rd);
      end
      tick();
      checks++;
      if (ovld4 !== 1'b1 || osrc4 !== exp_src || odata4 !== exp_data) begin
        errors++;
        $display("FAIL fair_out beat %0d: got vld=%b src=%0d data=%h expected vld=1 src=%0d data=%h",
                 j, ovld4, osrc4, odata4, exp_src, exp_data);
      end
      data4[exp_src*8 +: 8] = 8'(exp_data + 8'h01);
    end
  endtask

  task automatic test_frame_lock();
    do_reset();
    // One last beat from input 1 moves ptr to 2.
    vld4  = 4'b0010;
    last4 = 4'b0010;
    data4 = 32'h00_00_AA_00;
    tick();
    checks++;
    if (osrc4 !== 2'd1 || odata4 !== 8'hAA) begin
      errors++;
      $display("FAIL lock_setup: got src=%0d data=%h expected src=1 data=aa", osrc4, odata4);
    end
    vld4  = 4'b0101;
    last4 = 4'b0001;
    data4 = 32'h00_20_00_01;
    for (int b = 0; b < 3; b++) begin
      data4[23:16] = 8'(8'h20 + b);
      last4[2]     = (b == 2);
      #1;
      checks++;
      if (rd4 !== 4'b0100) begin
        errors++;
        $display("FAIL lock_rd beat %0d: got %b expected 0100", b, rd4);
      end
      if (b > 0) begin
        checks++;
        if (busy4 !== 1'b1) begin
          errors++;
          $display("FAIL lock_busy beat %0d: got %b expected 1", b, busy4);
        end
      end
      tick();
      checks++;
      if (ovld4 !== 1'b1 || osrc4 !== 2'd2 || odata4 !== 8'(8'h20 + b) || olast4 !== (b == 2)) begin
        errors++;
        $display("FAIL lock_out beat %0d: got vld=%b src=%0d data=%h last=%b expected src=2 data=%h",
                 b, ovld4, osrc4, odata4, olast4, 8'(8'h20 + b));
      end
    end
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL lock_release_busy: got %b expected 0", busy4);
    end
    last4 = 4'b0101;
    #1;
    checks++;
    if (rd4 !== 4'b0001) begin
      errors++;
      $display("FAIL lock_wrap_rd: got %b expected 0001", rd4);
    end
    tick();
    checks++;
    if (osrc4 !== 2'd0 || odata4 !== 8'h01) begin
      errors++;
      $display("FAIL lock_wrap_out: got src=%0d data=%h expected src=0 data=01", osrc4, odata4);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    vld4  = 4'b0010;
    last4 = 4'b0010;
    data4 = 32'h00_00_50_00;
    tick();
    data4[15:8] = 8'h51;
    ordy4 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rd4 !== 4'b0000) begin
        errors++;
        $display("FAIL bp_rd cycle %0d: got %b expected 0000", c, rd4);
      end
      tick();
      checks++;
      if (ovld4 !== 1'b1 || odata4 !== 8'h50 || osrc4 !== 2'd1 || olast4 !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got vld=%b data=%h src=%0d last=%b expected vld=1 data=50 src=1 last=1",
                 c, ovld4, odata4, osrc4, olast4);
      end
    end
    ordy4 = 1'b1;
    #1;
    checks++;
    if (rd4 !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_rd: got %b expected 0010", rd4);
    end
    tick();
    checks++;
    if (ovld4 !== 1'b1 || odata4 !== 8'h51) begin
      errors++;
      $display("FAIL bp_next_beat: got vld=%b data=%h expected vld=1 data=51", ovld4, odata4);
    end
    data4[15:8] = 8'h52;
    tick();
    checks++;
    if (ovld4 !== 1'b1 || odata4 !== 8'h52) begin
      errors++;
      $display("FAIL bp_following_beat: got vld=%b data=%h expected vld=1 data=52", ovld4, odata4);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    // One last beat from input 0 moves ptr to 1.
    vld4  = 4'b0001;
    last4 = 4'b0001;
    data4 = 32'h00_00_00_0F;
    tick();
    vld4  = 4'b0011;
    last4 = 4'b0001;
    data4 = 32'h00_00_31_01;
    #1;
    checks++;
    if (rd4 !== 4'b0010) begin
      errors++;
      $display("FAIL bubble_first_rd: got %b expected 0010", rd4);
    end
    tick();
    checks++;
    if (osrc4 !== 2'd1 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL bubble_locked: got src=%0d busy=%b expected src=1 busy=1", osrc4, busy4);
    end
    vld4 = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rd4 !== 4'b0000) begin
        errors++;
        $display("FAIL bubble_rd cycle %0d: got %b expected 0000", c, rd4);
      end
      tick();
      checks++;
      if (ovld4 !== 1'b0 || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL bubble_drain cycle %0d: got vld=%b busy=%b expected vld=0 busy=1", c, ovld4, busy4);
      end
    end
    vld4  = 4'b0011;
    last4 = 4'b0011;
    data4 = 32'h00_00_32_01;
    #1;
    checks++;
    if (rd4 !== 4'b0010) begin
      errors++;
      $display("FAIL bubble_resume_rd: got %b expected 0010", rd4);
    end
    tick();
    checks++;
    if (ovld4 !== 1'b1 || osrc4 !== 2'd1 || odata4 !== 8'h32 || olast4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL bubble_resume_out: got vld=%b src=%0d data=%h last=%b busy=%b expected 1 1 32 1 0",
               ovld4, osrc4, odata4, olast4, busy4);
    end
    #1;
    checks++;
    if (rd4 !== 4'b0001) begin
      errors++;
      $display("FAIL bubble_then_input0_rd: got %b expected 0001", rd4);
    end
    tick();
    checks++;
    if (osrc4 !== 2'd0 || odata4 !== 8'h01) begin
      errors++;
      $display("FAIL bubble_then_input0_out: got src=%0d data=%h expected src=0 data=01", osrc4, odata4);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    vld4  = 4'b1000;
    last4 = 4'b0000;
    data4 = 32'h70_00_00_00;
    #1;
    checks++;
    if (rd4 !== 4'b1000) begin
      errors++;
      $display("FAIL rmf_first_rd: got %b expected 1000", rd4);
    end
    tick();
    checks++;
    if (busy4 !== 1'b1 || osrc4 !== 2'd3) begin
      errors++;
      $display("FAIL rmf_locked: got busy=%b src=%0d expected busy=1 src=3", busy4, osrc4);
    end
    rst   = 1'b1;
    vld4  = 4'b1010;
    last4 = 4'b1111;
    data4 = 32'h71_00_11_00;
    #1;
    checks++;
    if (rd4 !== 4'b0000) begin
      errors++;
      $display("FAIL rmf_rd_in_reset: got %b expected 0000", rd4);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (busy4 !== 1'b0 || ovld4 !== 1'b0) begin
      errors++;
      $display("FAIL rmf_after_reset: got busy=%b vld=%b expected busy=0 vld=0", busy4, ovld4);
    end
    #1;
    checks++;
    if (rd4 !== 4'b0010) begin
      errors++;
      $display("FAIL rmf_grant_rd: got %b expected 0010", rd4);
    end
    tick();
    checks++;
    if (osrc4 !== 2'd1 || odata4 !== 8'h11) begin
      errors++;
      $display("FAIL rmf_grant_out: got src=%0d data=%h expected src=1 data=11", osrc4, odata4);
    end
  endtask

  task automatic test_non_pow2();
    logic [2:0] exp_rd;
    logic [1:0] exp_src;
    do_reset();
    vld3  = 3'b111;
    last3 = 3'b111;
    data3 = 24'h20_10_00;
    ordy3 = 1'b1;
    for (int j = 0; j < 7; j++) begin
      exp_src = 2'(j % 3);
      exp_rd  = 3'b001 << exp_src;
      #1;
      checks++;
      if (rd3 !== exp_rd) begin
        errors++;
        $display("FAIL np2_rd beat %0d: got %b expected %b", j, rd3, exp_rd);
      end
      tick();
      checks++;
      if (ovld3 !== 1'b1 || osrc3 !== exp_src || odata3 !== 8'(8'h10 * (j % 3))) begin
        errors++;
        $display("FAIL np2_out beat %0d: got vld=%b src=%0d data=%h expected vld=1 src=%0d data=%h",
                 j, ovld3, osrc3, odata3, exp_src, 8'(8'h10 * (j % 3)));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fairness();
    test_frame_lock();
    test_backpressure();
    test_bubble();
    test_reset_mid_frame();
    test_non_pow2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
